// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and sizing helper for the fifo push arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, LOCKED} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: producer request side plus std_fifo write side of the arbiter
interface fifo_push_arbiter_if #(parameter int NUM_REQ = 4, parameter int WIDTH = 8);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*WIDTH-1:0] req_d;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] gnt;
  logic fifo_push;
  logic [WIDTH-1:0] fifo_d;
  logic fifo_full;
  logic fifo_almost_full;
  modport slave (
    input req, req_d, req_last, fifo_full, fifo_almost_full,
    output gnt, fifo_push, fifo_d
  );
  modport master (
    output req, req_d, req_last, fifo_full, fifo_almost_full,
    input gnt, fifo_push, fifo_d
  );
endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req at or above ptr (wrapping)
module rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic found;
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    end
    grant = (enable && found) ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, burst-locking arbiter sharing one std_fifo write port
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int MAX_BURST = 16,
  parameter int ID_W = clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            rst,
  fifo_push_arbiter_if.slave bus,
  output logic            busy,
  output logic [ID_W-1:0] owner,
  output logic            err_burst
);
  localparam int CNT_W = clog2(MAX_BURST + 1);
  state_t state, state_n;
  logic [ID_W-1:0] rr_ptr, rr_n, owner_n, pick_idx, sel;
  logic [CNT_W-1:0] beat_cnt, cnt_n;
  logic [NUM_REQ-1:0] pick_gnt, gnt;
  logic space, take, last, err_n, push;
  logic [WIDTH-1:0] beat, data;
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction
  // the registered push still in flight consumes the last free slot
  assign space = !bus.fifo_full && !(push && bus.fifo_almost_full);
  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req(bus.req), .ptr(rr_ptr), .enable(space && state == IDLE),
    .grant(pick_gnt), .idx(pick_idx)
  );
  assign sel = (state == IDLE) ? pick_idx : owner;
  assign gnt = !rst ? '0 : (state == IDLE) ? pick_gnt :
               (bus.req[owner] && space) ? NUM_REQ'(1) << owner : '0;
  assign take = |gnt;
  assign last = bus.req_last[sel];
  assign beat = bus.req_d[sel*WIDTH +: WIDTH];
  assign bus.gnt = gnt;
  assign bus.fifo_push = push;
  assign bus.fifo_d = data;
  assign busy = (state == LOCKED);
  always_comb begin
    state_n = state;
    rr_n = rr_ptr;
    owner_n = owner;
    cnt_n = beat_cnt;
    err_n = 1'b0;
    if (take && state == IDLE) begin
      owner_n = sel;
      rr_n = last ? next_id(sel) : rr_ptr;
      state_n = last ? IDLE : LOCKED;
      cnt_n = last ? beat_cnt : CNT_W'(1);
    end else if (take) begin
      if (last || beat_cnt == CNT_W'(MAX_BURST - 1)) begin
        state_n = IDLE;
        rr_n = next_id(owner);
        cnt_n = '0;
        err_n = !last;
      end else begin
        cnt_n = beat_cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      beat_cnt <= '0;
      push <= 1'b0;
      data <= '0;
      err_burst <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_n;
      owner <= owner_n;
      beat_cnt <= cnt_n;
      push <= take;
      data <= take ? beat : data;
      err_burst <= err_n;
    end
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed scenarios against a behavioural 16-deep std_fifo model
module tb_fifo_push_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  fifo_push_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus ();
  logic busy, err_burst;
  logic [1:0] owner;
  fifo_push_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .owner(owner), .err_burst(err_burst)
  );
  int checks = 0;
  int failures = 0;
  int pwf = 0;
  logic pop = 1'b0;
  logic [4:0] fcnt;
  logic [7:0] fq[$];
  logic pu, po;
  assign pu = bus.fifo_push && fcnt != 5'd16;
  assign po = pop && fcnt != 5'd0;
  assign bus.fifo_full = (fcnt == 5'd16);
  assign bus.fifo_almost_full = (fcnt >= 5'd15);
  // std_fifo model, sharing the arbiter's reset net
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt <= '0;
      fq.delete();
    end else begin
      if (bus.fifo_push && fcnt == 5'd16) pwf <= pwf + 1;
      fcnt <= fcnt + 5'(pu) - 5'(po);
      if (pu) fq.push_back(bus.fifo_d);
      if (po) void'(fq.pop_front());
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req = '0;
    pop = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = 4'b1111;
    bus.req_last = 4'b1111;
    bus.req_d = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (bus.fifo_push !== 1'b0) begin failures++; $display("FAIL rst_push got=%b exp=0", bus.fifo_push); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL rst_owner got=%0d exp=0", owner); end
    checks++; if (err_burst !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_burst); end
    bus.req = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.req_d[7:0] = 8'hA5;
    bus.req_last = 4'b1111;
    bus.req = 4'b0001;
    #1;
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", bus.gnt); end
    @(negedge clk);
    bus.req = '0;
    #1;
    checks++; if (bus.fifo_push !== 1'b1) begin failures++; $display("FAIL single_push got=%b exp=1", bus.fifo_push); end
    checks++; if (bus.fifo_d !== 8'hA5) begin failures++; $display("FAIL single_d got=%h exp=a5", bus.fifo_d); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL single_owner got=%0d exp=0", owner); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
    @(negedge clk);
    #1;
    checks++; if (bus.fifo_push !== 1'b0) begin failures++; $display("FAIL single_push_drop got=%b exp=0", bus.fifo_push); end
  endtask

  task automatic test_rotate();
    logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] ed [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();
    for (int i = 0; i < 4; i++) bus.req_d[i*8 +: 8] = 8'(8'h10 + i);
    bus.req_last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) bus.req = 4'b1111;
      #1;
      checks++; if (bus.gnt !== eg[k]) begin failures++; $display("FAIL rotate_gnt%0d got=%b exp=%b", k, bus.gnt, eg[k]); end
    end
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    #1;
    checks++; if (fq.size() != 5) begin failures++; $display("FAIL rotate_count got=%0d exp=5", fq.size()); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (fq[0] !== ed[k]) begin failures++; $display("FAIL rotate_q%0d got=%h exp=%h", k, fq[0], ed[k]); end
      pop = 1'b1;
      @(negedge clk);
      #1;
    end
    pop = 1'b0;
  endtask

  task automatic test_burst();
    bus.req_last = 4'b1011;
    @(negedge clk);
    bus.req_d[23:16] = 8'h11;
    bus.req = 4'b0100;
    #1;
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL burst_gnt1 got=%b exp=0100", bus.gnt); end
    @(negedge clk);
    bus.req_d[23:16] = 8'h22;
    bus.req = 4'b1111;
    #1;
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL burst_gnt2 got=%b exp=0100", bus.gnt); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL burst_busy got=%b exp=1", busy); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.req = 4'b1011;
      #1;
      checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL burst_stall%0d got=%b exp=0000", k, bus.gnt); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL burst_stall_busy%0d got=%b exp=1", k, busy); end
    end
    @(negedge clk);
    bus.req_d[23:16] = 8'h33;
    bus.req_last = 4'b1111;
    bus.req = 4'b1111;
    #1;
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL burst_gnt3 got=%b exp=0100", bus.gnt); end
    @(negedge clk);
    #1;
    checks++; if (bus.fifo_d !== 8'h33) begin failures++; $display("FAIL burst_d3 got=%h exp=33", bus.fifo_d); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_release got=%b exp=0", busy); end
    checks++; if (bus.gnt !== 4'b1000) begin failures++; $display("FAIL burst_next got=%b exp=1000", bus.gnt); end
    @(negedge clk);
    bus.req = '0;
  endtask

  task automatic test_full();
    int n = 0;
    do_reset();
    bus.req_d[7:0] = 8'h5A;
    bus.req_last = 4'b1111;
    @(negedge clk);
    bus.req = 4'b0001;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (bus.gnt[0]) n++;
      @(negedge clk);
    end
    #1;
    checks++; if (n != 16) begin failures++; $display("FAIL full_grants got=%0d exp=16", n); end
    checks++; if (bus.fifo_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", bus.fifo_full); end
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL full_gnt got=%b exp=0000", bus.gnt); end
    pop = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pop = 1'b0;
      #1;
      if (bus.gnt[0]) n++;
    end
    checks++; if (n != 1) begin failures++; $display("FAIL full_pop_grants got=%0d exp=1", n); end
    checks++; if (pwf != 0) begin failures++; $display("FAIL full_push_while_full got=%0d exp=0", pwf); end
    bus.req = '0;
  endtask

  task automatic test_watchdog();
    do_reset();
    pop = 1'b1;
    bus.req_last = 4'b0100;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) bus.req = 4'b0110;
      #1;
      checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL wd_gnt%0d got=%b exp=0010", k, bus.gnt); end
    end
    checks++; if (err_burst !== 1'b0) begin failures++; $display("FAIL wd_err_early got=%b exp=0", err_burst); end
    @(negedge clk);
    #1;
    checks++; if (err_burst !== 1'b1) begin failures++; $display("FAIL wd_err got=%b exp=1", err_burst); end
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL wd_next got=%b exp=0100", bus.gnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wd_busy got=%b exp=0", busy); end
    @(negedge clk);
    bus.req = '0;
    #1;
    checks++; if (err_burst !== 1'b0) begin failures++; $display("FAIL wd_err_pulse got=%b exp=0", err_burst); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pop = 1'b1;
    bus.req_last = 4'b0010;
    @(negedge clk);
    bus.req = 4'b0010;
    #1;
    checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL rm_single got=%b exp=0010", bus.gnt); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.req = 4'b0100;
      bus.req_d[23:16] = 8'(k + 1);
      #1;
      checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL rm_beat%0d got=%b exp=0100", k + 1, bus.gnt); end
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rm_busy_pre got=%b exp=1", busy); end
    rst = 1'b0;
    #1;
    checks++; if (bus.fifo_push !== 1'b0) begin failures++; $display("FAIL rm_push got=%b exp=0", bus.fifo_push); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL rm_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL rm_owner got=%0d exp=0", owner); end
    @(negedge clk);
    rst = 1'b1;
    bus.req_last = 4'b1111;
    bus.req = 4'b1111;
    #1;
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL rm_restart got=%b exp=0001", bus.gnt); end
    @(negedge clk);
    bus.req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_burst();
    test_full();
    test_watchdog();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
